// File: rtl/div_result_display.sv
//==============================================================================
// Module   : div_result_display
// Purpose  : Captures an 8-bit quotient/remainder pair on a load strobe,
//            converts each value to three BCD digits with a serial
//            shift-add-3 engine, and drives a 6-digit multiplexed
//            common-anode 7-segment display. Quotient is shown on digits
//            5..3 and remainder on digits 2..0. A zero divisor shows "Err".
// Ports    : clk   - system clock (rising edge)
//            rst   - synchronous active-high reset
//            load  - one-cycle strobe, samples quo/rem/div0
//            quo   - quotient [7:0]
//            rem   - remainder [7:0]
//            div0  - divisor-was-zero flag
//            busy  - conversion in progress, load ignored
//            done  - one-cycle pulse when the display is updated
//            an    - digit enables, active-low one-hot (an[0] rightmost)
//            seg   - segments {g,f,e,d,c,b,a}, active-low
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_result_display #(
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] quo,
    input  logic [7:0] rem,
    input  logic       div0,
    output logic       busy,
    output logic       done,
    output logic [5:0] an,
    output logic [6:0] seg
);

    localparam logic [6:0]       c_BLANK    = 7'h7F;
    localparam logic [6:0]       c_SEG_E    = 7'h06;
    localparam logic [6:0]       c_SEG_R    = 7'h2F;
    localparam logic [CNT_W-1:0] c_PRE_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV_Q = 2'd1,
        S_CONV_R = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_busy;
    logic        r_done;
    logic        r_div0;
    logic [7:0]  r_q_sh;
    logic [7:0]  r_r_sh;
    logic [11:0] r_acc;
    logic [11:0] r_q_bcd;
    logic [2:0]  r_bit;
    logic [6:0]  r_dig0, r_dig1, r_dig2, r_dig3, r_dig4, r_dig5;
    logic [CNT_W-1:0] r_pre;
    logic [2:0]  r_idx;
    logic [5:0]  r_an;
    logic [6:0]  r_seg;

    logic        w_start;
    logic        w_bit_in;
    logic [11:0] w_acc_nxt;
    logic [6:0]  w_q2, w_q1, w_q0, w_r2, w_r1, w_r0;
    logic [5:0]  w_an_sel;
    logic [6:0]  w_seg_sel;

    function automatic logic [3:0] f_add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // A new result is accepted only once the previous one has fully
    // retired (busy stays high for the cycle after COMMIT).
    assign w_start  = (r_state == S_IDLE) && load && !r_busy;
    assign w_bit_in = (r_state == S_CONV_Q) ? r_q_sh[7] : r_r_sh[7];

    // One double-dabble step. The hundreds nibble of an 8-bit value never
    // exceeds 2, so it needs no correction and its top bit never shifts out.
    assign w_acc_nxt = {r_acc[10:8], f_add3(r_acc[7:4]), f_add3(r_acc[3:0]), w_bit_in};

    // Leading-zero blanking per 3-digit group; ones digit always shown.
    always_comb begin
        w_q2 = (r_q_bcd[11:8] == 4'd0) ? c_BLANK : f_seg(r_q_bcd[11:8]);
        w_q1 = (r_q_bcd[11:4] == 8'd0) ? c_BLANK : f_seg(r_q_bcd[7:4]);
        w_q0 = f_seg(r_q_bcd[3:0]);
        w_r2 = (r_acc[11:8] == 4'd0) ? c_BLANK : f_seg(r_acc[11:8]);
        w_r1 = (r_acc[11:4] == 8'd0) ? c_BLANK : f_seg(r_acc[7:4]);
        w_r0 = f_seg(r_acc[3:0]);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_CONV_Q;
            S_CONV_Q: if (r_bit == 3'd7) w_state_nxt = S_CONV_R;
            S_CONV_R: if (r_bit == 3'd7) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_q_sh  <= 8'd0;
            r_r_sh  <= 8'd0;
            r_acc   <= 12'd0;
            r_q_bcd <= 12'd0;
            r_bit   <= 3'd0;
            r_dig0  <= c_BLANK;
            r_dig1  <= c_BLANK;
            r_dig2  <= c_BLANK;
            r_dig3  <= c_BLANK;
            r_dig4  <= c_BLANK;
            r_dig5  <= c_BLANK;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_q_sh <= quo;
                        r_r_sh <= rem;
                        r_div0 <= div0;
                        r_acc  <= 12'd0;
                        r_bit  <= 3'd0;
                        r_busy <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_CONV_Q: begin
                    r_q_sh <= {r_q_sh[6:0], 1'b0};
                    r_bit  <= r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        r_q_bcd <= w_acc_nxt;
                        r_acc   <= 12'd0;
                    end else begin
                        r_acc <= w_acc_nxt;
                    end
                end
                S_CONV_R: begin
                    r_r_sh <= {r_r_sh[6:0], 1'b0};
                    r_bit  <= r_bit + 3'd1;
                    r_acc  <= w_acc_nxt;
                end
                S_COMMIT: begin
                    r_done <= 1'b1;
                    if (r_div0) begin
                        r_dig5 <= c_SEG_E;
                        r_dig4 <= c_SEG_R;
                        r_dig3 <= c_SEG_R;
                        r_dig2 <= c_BLANK;
                        r_dig1 <= c_BLANK;
                        r_dig0 <= c_BLANK;
                    end else begin
                        r_dig5 <= w_q2;
                        r_dig4 <= w_q1;
                        r_dig3 <= w_q0;
                        r_dig2 <= w_r2;
                        r_dig1 <= w_r1;
                        r_dig0 <= w_r0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_an_sel  = 6'b111111;
        w_seg_sel = c_BLANK;
        case (r_idx)
            3'd0: begin w_an_sel = 6'b111110; w_seg_sel = r_dig0; end
            3'd1: begin w_an_sel = 6'b111101; w_seg_sel = r_dig1; end
            3'd2: begin w_an_sel = 6'b111011; w_seg_sel = r_dig2; end
            3'd3: begin w_an_sel = 6'b110111; w_seg_sel = r_dig3; end
            3'd4: begin w_an_sel = 6'b101111; w_seg_sel = r_dig4; end
            3'd5: begin w_an_sel = 6'b011111; w_seg_sel = r_dig5; end
            default: ;
        endcase
    end

    // Scan runs freely; an and seg are registered from the same index so
    // they always change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= 3'd0;
            r_an  <= 6'b111110;
            r_seg <= c_BLANK;
        end else begin
            r_an  <= w_an_sel;
            r_seg <= w_seg_sel;
            if (r_pre == c_PRE_LAST) begin
                r_pre <= '0;
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign an   = r_an;
    assign seg  = r_seg;

endmodule

`default_nettype wire
